// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave):
// a single outstanding req/ack access with byte enables and lane-replicated write data.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: sub-word loads/stores over a req/ack bus, FREEZE stall, timeout abort.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       aluResult1_PR,
    input  logic [31:0]       readDataB1_PR,
    input  logic [31:0]       Instr1_PR,
    input  logic [4:0]        writeRegister1_PR,
    input  logic              MemRead1_PR,
    input  logic              MemWrite1_PR,
    input  logic              MemtoReg1_PR,
    input  logic              do_writeback1_PR,
    mem_stage_if.master       dmem,
    output logic              FREEZE,
    output logic [31:0]       Data1_MEM,
    output logic [4:0]        writeRegister1_MEM,
    output logic              do_writeback1_MEM,
    output logic [31:0]       Data1_WB,
    output logic [4:0]        writeRegister1_WB,
    output logic              do_writeback1_WB,
    output logic              bus_err,
    output logic              align_err
);
    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SW  = 6'h2B;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       opc;
    logic [1:0]       lo;
    logic             is_byte, is_half, mem_op, misalign, issue, ack_v;
    logic             unused_instr;

    function automatic logic [3:0] be_f(input logic b_acc, input logic h_acc, input logic [1:0] a);
        if (b_acc)      return 4'b0001 << a;
        else if (h_acc) return a[1] ? 4'b1100 : 4'b0011;
        else            return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_f(input logic b_acc, input logic h_acc, input logic [31:0] d);
        if (b_acc)      return {4{d[7:0]}};
        else if (h_acc) return {2{d[15:0]}};
        else            return d;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] rd, input logic [5:0] op, input logic [1:0] a);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h   = a[1] ? rd[31:16] : rd[15:0];
        b_s = b;
        h_s = h;
        case (op)
            OP_LB:   ext = b_s;
            OP_LH:   ext = h_s;
            OP_LBU:  ext = {24'h0, b};
            OP_LHU:  ext = {16'h0, h};
            default: ext = rd;
        endcase
        return ext;
    endfunction

    assign opc          = Instr1_PR[31:26];
    assign lo           = aluResult1_PR[1:0];
    assign unused_instr = ^Instr1_PR[25:0];
    assign is_byte      = (opc == OP_LB) | (opc == OP_LBU) | (opc == OP_SB);
    assign is_half      = (opc == OP_LH) | (opc == OP_LHU) | (opc == OP_SH);
    assign mem_op       = MemRead1_PR | MemWrite1_PR;

`ifdef MEM_ALIGN_CHECK_EN
    logic is_word_chk;
    assign is_word_chk = (opc == OP_LW) | (opc == OP_SW);
    assign misalign    = mem_op & ((is_half & lo[0]) | (is_word_chk & (lo != 2'b00)));
`else
    assign misalign    = 1'b0;
    assign align_err   = 1'b0;
`endif

    // Request is gated by RESET so it drops the instant reset asserts, even mid-access.
    assign issue  = RESET & mem_op & ~misalign & (state != ABORT);
    assign ack_v  = dmem.dmem_ack & issue;
    assign FREEZE = issue & ~dmem.dmem_ack;

    assign dmem.dmem_req   = issue;
    assign dmem.dmem_we    = MemWrite1_PR;
    assign dmem.dmem_addr  = {aluResult1_PR[31:2], 2'b00};
    assign dmem.dmem_be    = be_f(is_byte, is_half, lo);
    assign dmem.dmem_wdata = wdata_f(is_byte, is_half, readDataB1_PR);

    assign Data1_MEM          = MemtoReg1_PR ? load_f(dmem.dmem_rdata, opc, lo) : aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & (~MemRead1_PR | ack_v);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= IDLE;
            cnt               <= '0;
            bus_err           <= 1'b0;
            Data1_WB          <= '0;
            writeRegister1_WB <= '0;
            do_writeback1_WB  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (issue & ~dmem.dmem_ack) begin
                    state <= BUSY;
                    cnt   <= '0;
                end
                BUSY: if (ack_v) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == CNT_LAST) begin
                    state   <= ABORT;
                    bus_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ABORT: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase

            // MEM/WB: retire when not frozen; an abort or alignment trap retires without writeback.
            if (!FREEZE) begin
                Data1_WB          <= Data1_MEM;
                writeRegister1_WB <= writeRegister1_MEM;
                do_writeback1_WB  <= do_writeback1_MEM & (state != ABORT) & ~misalign;
            end else begin
                do_writeback1_WB  <= 1'b0;
            end
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= misalign;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, sub-word loads/stores, wait states, timeout abort, alignment.
// Expected values are hand-computed constants; MEM_ALIGN_CHECK_EN selects the alignment expectation.
module tb_mem_stage;
    localparam int TIMEOUT_CYC = 1023;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] aluResult1_PR, readDataB1_PR, Instr1_PR;
    logic [4:0]  writeRegister1_PR;
    logic        MemRead1_PR, MemWrite1_PR, MemtoReg1_PR, do_writeback1_PR;
    logic        FREEZE;
    logic [31:0] Data1_MEM, Data1_WB;
    logic [4:0]  writeRegister1_MEM, writeRegister1_WB;
    logic        do_writeback1_MEM, do_writeback1_WB, bus_err, align_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(10)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .aluResult1_PR      (aluResult1_PR),
        .readDataB1_PR      (readDataB1_PR),
        .Instr1_PR          (Instr1_PR),
        .writeRegister1_PR  (writeRegister1_PR),
        .MemRead1_PR        (MemRead1_PR),
        .MemWrite1_PR       (MemWrite1_PR),
        .MemtoReg1_PR       (MemtoReg1_PR),
        .do_writeback1_PR   (do_writeback1_PR),
        .dmem               (bus),
        .FREEZE             (FREEZE),
        .Data1_MEM          (Data1_MEM),
        .writeRegister1_MEM (writeRegister1_MEM),
        .do_writeback1_MEM  (do_writeback1_MEM),
        .Data1_WB           (Data1_WB),
        .writeRegister1_WB  (writeRegister1_WB),
        .do_writeback1_WB   (do_writeback1_WB),
        .bus_err            (bus_err),
        .align_err          (align_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic m2r, input logic wb);
        Instr1_PR         = {op, 26'h0};
        aluResult1_PR     = addr;
        readDataB1_PR     = wd;
        writeRegister1_PR = rd;
        MemRead1_PR       = mr;
        MemWrite1_PR      = mw;
        MemtoReg1_PR      = m2r;
        do_writeback1_PR  = wb;
    endtask

    task automatic idle_instr();
        drive(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        drive(op, addr, 32'h0, rd, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_rdata = rdata;
        bus.dmem_ack   = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            check({tag, "_freeze"}, FREEZE, 1);
            check({tag, "_be_wait"}, bus.dmem_be, exp_be);
            tick();
            check({tag, "_bubble"}, do_writeback1_WB, 0);
        end
        bus.dmem_ack = 1'b1;
        @(negedge CLK);
        check({tag, "_freeze_ack"}, FREEZE, 0);
        check({tag, "_req"}, bus.dmem_req, 1);
        check({tag, "_we"}, bus.dmem_we, 0);
        check({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, bus.dmem_be, exp_be);
        check({tag, "_fwd_data"}, Data1_MEM, exp_data);
        check({tag, "_fwd_wb"}, do_writeback1_MEM, 1);
        tick();
        check({tag, "_wb_data"}, Data1_WB, exp_data);
        check({tag, "_wb_reg"}, writeRegister1_WB, rd);
        check({tag, "_wb_en"}, do_writeback1_WB, 1);
        bus.dmem_ack = 1'b0;
        idle_instr();
    endtask

    task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int waits,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        drive(op, addr, wd, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.dmem_ack = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            check({tag, "_freeze"}, FREEZE, 1);
            check({tag, "_wdata_wait"}, bus.dmem_wdata, exp_wdata);
            tick();
        end
        bus.dmem_ack = 1'b1;
        @(negedge CLK);
        check({tag, "_freeze_ack"}, FREEZE, 0);
        check({tag, "_we"}, bus.dmem_we, 1);
        check({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, bus.dmem_be, exp_be);
        check({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
        tick();
        check({tag, "_wb_en"}, do_writeback1_WB, 0);
        bus.dmem_ack = 1'b0;
        idle_instr();
    endtask

    initial begin
        int frz;
        RESET          = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        idle_instr();
        repeat (2) tick();
        check("rst_req", bus.dmem_req, 0);
        check("rst_wb_data", Data1_WB, 0);
        check("rst_wb_en", do_writeback1_WB, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_align_err", align_err, 0);
        RESET = 1'b1;
        tick();

        // Non-memory op retires in one cycle with the ALU result.
        drive(6'h00, 32'h12345678, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        check("alu_freeze", FREEZE, 0);
        check("alu_req", bus.dmem_req, 0);
        check("alu_fwd", Data1_MEM, 32'h12345678);
        tick();
        check("alu_wb_data", Data1_WB, 32'h12345678);
        check("alu_wb_reg", writeRegister1_WB, 3);
        check("alu_wb_en", do_writeback1_WB, 1);

        // Reset in the middle of an outstanding load.
        drive(6'h23, 32'h300, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        @(negedge CLK);
        check("busy_req", bus.dmem_req, 1);
        check("busy_freeze", FREEZE, 1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midrst_req", bus.dmem_req, 0);
        check("midrst_freeze", FREEZE, 0);
        check("midrst_wb_data", Data1_WB, 0);
        check("midrst_wb_reg", writeRegister1_WB, 0);
        idle_instr();
        tick();
        RESET = 1'b1;
        tick();
        check("postrst_wb_en", do_writeback1_WB, 0);

        do_load("lw0",  6'h23, 32'h100, 32'hDEADBEEF, 5'd5,  0, 4'b1111, 32'hDEADBEEF);
        do_load("lb3",  6'h20, 32'h103, 32'h80112233, 5'd6,  3, 4'b1000, 32'hFFFFFF80);
        do_load("lbu3", 6'h24, 32'h103, 32'h80112233, 5'd6,  3, 4'b1000, 32'h00000080);
        do_load("lb1",  6'h20, 32'h101, 32'h11227F33, 5'd10, 0, 4'b0010, 32'h0000007F);
        do_load("lh0",  6'h21, 32'h100, 32'h12348765, 5'd8,  1, 4'b0011, 32'hFFFF8765);
        do_load("lhu2", 6'h25, 32'h102, 32'h8001ABCD, 5'd9,  0, 4'b1100, 32'h00008001);

        do_store("sh2", 6'h29, 32'h202, 32'h0000ABCD, 0, 4'b1100, 32'hABCDABCD);
        do_store("sb1", 6'h28, 32'h201, 32'h123456EE, 0, 4'b0010, 32'hEEEEEEEE);
        do_store("sw4", 6'h2B, 32'h204, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D);

        // Timeout: ack withheld until the stage aborts.
        drive(6'h23, 32'h400, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_ack = 1'b0;
        frz = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            if (!FREEZE) break;
            frz++;
        end
        check("to_freeze_cycles", frz, TIMEOUT_CYC + 1);
        check("to_abort_req", bus.dmem_req, 0);
        check("to_bus_err", bus_err, 1);
        @(posedge CLK);
        #1;
        check("to_wb_en", do_writeback1_WB, 0);
        drive(6'h00, 32'h0000A5A5, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("after_abort_data", Data1_WB, 32'h0000A5A5);
        check("after_abort_wb", do_writeback1_WB, 1);
        check("bus_err_sticky", bus_err, 1);
        idle_instr();
        do_load("lw_post", 6'h23, 32'h500, 32'h01020304, 5'd14, 0, 4'b1111, 32'h01020304);
        check("bus_err_sticky2", bus_err, 1);

`ifdef MEM_ALIGN_CHECK_EN
        drive(6'h23, 32'h102, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_rdata = 32'h11111111;
        @(negedge CLK);
        check("al_req", bus.dmem_req, 0);
        check("al_freeze", FREEZE, 0);
        tick();
        check("al_err_pulse", align_err, 1);
        check("al_wb_en", do_writeback1_WB, 0);
        idle_instr();
        tick();
        check("al_err_clear", align_err, 0);
`else
        do_load("lw_unal", 6'h23, 32'h102, 32'h55AA55AA, 5'd13, 0, 4'b1111, 32'h55AA55AA);
        check("al_err_tied", align_err, 0);
`endif

        RESET = 1'b0;
        #1;
        check("final_rst_bus_err", bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
